// File: rtl/data_mem_axi_bridge.sv
// Bridges the CPU data-memory request/response handshake onto single-beat AXI4
// read and write transactions, with at most one transaction outstanding.
module data_mem_axi_bridge #(
  parameter int AXI_ADDR_WIDTH = 40
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_reset_n,
  input  logic [31:0]               Address,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic [31:0]               Write_data,
  input  logic [3:0]                Write_strb,
  output logic                      Mem_Req_Ready,
  output logic [31:0]               Read_data,
  output logic                      Read_data_Valid,
  input  logic                      Read_data_Ready,
  output logic [AXI_ADDR_WIDTH-1:0] cpu_mem_araddr,
  output logic                      cpu_mem_arvalid,
  input  logic                      cpu_mem_arready,
  output logic [2:0]                cpu_mem_arsize,
  output logic [1:0]                cpu_mem_arburst,
  output logic [7:0]                cpu_mem_arlen,
  input  logic [31:0]               cpu_mem_rdata,
  input  logic                      cpu_mem_rvalid,
  output logic                      cpu_mem_rready,
  input  logic                      cpu_mem_rlast,
  output logic [AXI_ADDR_WIDTH-1:0] cpu_mem_awaddr,
  output logic                      cpu_mem_awvalid,
  input  logic                      cpu_mem_awready,
  output logic [2:0]                cpu_mem_awsize,
  output logic [1:0]                cpu_mem_awburst,
  output logic [7:0]                cpu_mem_awlen,
  output logic [31:0]               cpu_mem_wdata,
  output logic [3:0]                cpu_mem_wstrb,
  output logic                      cpu_mem_wvalid,
  input  logic                      cpu_mem_wready,
  output logic                      cpu_mem_wlast,
  input  logic                      cpu_mem_bvalid,
  output logic                      cpu_mem_bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    RD_RSP,
    WR_REQ,
    WR_B
  } state_t;

  state_t      state;
  logic [31:2] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        aw_done;
  logic        w_done;
  logic        aw_fire;
  logic        w_fire;
  logic        unused_inputs;

  // rlast is redundant with a single-beat burst; byte offset is dropped by alignment
  assign unused_inputs = ^{cpu_mem_rlast, Address[1:0]};

  assign aw_fire = cpu_mem_awvalid && cpu_mem_awready;
  assign w_fire  = cpu_mem_wvalid && cpu_mem_wready;

  assign Mem_Req_Ready   = (state == IDLE);
  assign cpu_mem_araddr  = {{(AXI_ADDR_WIDTH-32){1'b0}}, addr, 2'b00};
  assign cpu_mem_awaddr  = {{(AXI_ADDR_WIDTH-32){1'b0}}, addr, 2'b00};
  assign cpu_mem_arsize  = 3'b010;
  assign cpu_mem_arburst = 2'b01;
  assign cpu_mem_arlen   = 8'd0;
  assign cpu_mem_awsize  = 3'b010;
  assign cpu_mem_awburst = 2'b01;
  assign cpu_mem_awlen   = 8'd0;
  assign cpu_mem_wdata   = wdata;
  assign cpu_mem_wstrb   = wstrb;
  assign cpu_mem_wlast   = 1'b1;

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state           <= IDLE;
      addr            <= '0;
      wdata           <= '0;
      wstrb           <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
      cpu_mem_arvalid <= 1'b0;
      cpu_mem_rready  <= 1'b0;
      cpu_mem_awvalid <= 1'b0;
      cpu_mem_wvalid  <= 1'b0;
      cpu_mem_bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A simultaneous read request is left pending; the write wins
          if (MemWrite) begin
            addr            <= Address[31:2];
            wdata           <= Write_data;
            wstrb           <= Write_strb;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            cpu_mem_awvalid <= 1'b1;
            cpu_mem_wvalid  <= 1'b1;
            state           <= WR_REQ;
          end else if (MemRead) begin
            addr            <= Address[31:2];
            cpu_mem_arvalid <= 1'b1;
            state           <= RD_AR;
          end
        end
        RD_AR: begin
          if (cpu_mem_arready) begin
            cpu_mem_arvalid <= 1'b0;
            cpu_mem_rready  <= 1'b1;
            state           <= RD_R;
          end
        end
        RD_R: begin
          if (cpu_mem_rvalid) begin
            cpu_mem_rready  <= 1'b0;
            Read_data       <= cpu_mem_rdata;
            Read_data_Valid <= 1'b1;
            state           <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            state           <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            cpu_mem_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_fire) begin
            cpu_mem_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          // Either channel may complete first; wait for the later of the two
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            cpu_mem_bready <= 1'b1;
            state          <= WR_B;
          end
        end
        WR_B: begin
          if (cpu_mem_bvalid) begin
            cpu_mem_bready <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_axi_bridge.sv
// Directed self-checking bench for data_mem_axi_bridge; the AXI slave is
// driven by hand so every handshake lands on a chosen cycle.
module tb_data_mem_axi_bridge;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset_n = 1'b0;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
  logic [39:0] cpu_mem_araddr;
  logic        cpu_mem_arvalid;
  logic        cpu_mem_arready = 1'b0;
  logic [2:0]  cpu_mem_arsize;
  logic [1:0]  cpu_mem_arburst;
  logic [7:0]  cpu_mem_arlen;
  logic [31:0] cpu_mem_rdata = '0;
  logic        cpu_mem_rvalid = 1'b0;
  logic        cpu_mem_rready;
  logic        cpu_mem_rlast = 1'b1;
  logic [39:0] cpu_mem_awaddr;
  logic        cpu_mem_awvalid;
  logic        cpu_mem_awready = 1'b0;
  logic [2:0]  cpu_mem_awsize;
  logic [1:0]  cpu_mem_awburst;
  logic [7:0]  cpu_mem_awlen;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_wvalid;
  logic        cpu_mem_wready = 1'b0;
  logic        cpu_mem_wlast;
  logic        cpu_mem_bvalid = 1'b0;
  logic        cpu_mem_bready;

  int checks = 0;
  int errors = 0;

  data_mem_axi_bridge #(.AXI_ADDR_WIDTH(40)) dut (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n),
    .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .cpu_mem_araddr(cpu_mem_araddr), .cpu_mem_arvalid(cpu_mem_arvalid),
    .cpu_mem_arready(cpu_mem_arready), .cpu_mem_arsize(cpu_mem_arsize),
    .cpu_mem_arburst(cpu_mem_arburst), .cpu_mem_arlen(cpu_mem_arlen),
    .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_rvalid(cpu_mem_rvalid),
    .cpu_mem_rready(cpu_mem_rready), .cpu_mem_rlast(cpu_mem_rlast),
    .cpu_mem_awaddr(cpu_mem_awaddr), .cpu_mem_awvalid(cpu_mem_awvalid),
    .cpu_mem_awready(cpu_mem_awready), .cpu_mem_awsize(cpu_mem_awsize),
    .cpu_mem_awburst(cpu_mem_awburst), .cpu_mem_awlen(cpu_mem_awlen),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_wvalid(cpu_mem_wvalid), .cpu_mem_wready(cpu_mem_wready),
    .cpu_mem_wlast(cpu_mem_wlast), .cpu_mem_bvalid(cpu_mem_bvalid),
    .cpu_mem_bready(cpu_mem_bready)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock: inputs set before this call are sampled at the posedge, outputs checked at the negedge
  task automatic applyStimulus();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  initial begin
    repeat (2) @(negedge cpu_clk);
    checkOutput("rst_req_ready", 64'(Mem_Req_Ready), 64'd1);
    checkOutput("rst_rd_valid", 64'(Read_data_Valid), 64'd0);
    checkOutput("rst_rdata", 64'(Read_data), 64'd0);
    checkOutput("rst_valids", 64'({cpu_mem_arvalid, cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_rready, cpu_mem_bready}), 64'd0);
    checkOutput("rst_addr", 64'(cpu_mem_araddr), 64'd0);
    cpu_reset_n = 1'b1;
    applyStimulus();

    // Zero-wait read
    $display("[TB] zero-wait read");
    MemRead = 1'b1; Address = 32'h0000_1006;
    checkOutput("rd0_req_ready", 64'(Mem_Req_Ready), 64'd1);
    applyStimulus();
    MemRead = 1'b0;
    checkOutput("rd0_arvalid", 64'(cpu_mem_arvalid), 64'd1);
    checkOutput("rd0_araddr", 64'(cpu_mem_araddr), 64'h00_0000_1004);
    checkOutput("rd0_arlen", 64'(cpu_mem_arlen), 64'd0);
    checkOutput("rd0_arsize", 64'(cpu_mem_arsize), 64'd2);
    checkOutput("rd0_arburst", 64'(cpu_mem_arburst), 64'd1);
    checkOutput("rd0_req_busy", 64'(Mem_Req_Ready), 64'd0);
    cpu_mem_arready = 1'b1;
    applyStimulus();
    cpu_mem_arready = 1'b0;
    checkOutput("rd0_rready", 64'({cpu_mem_arvalid, cpu_mem_rready}), 64'b01);
    checkOutput("rd0_no_valid", 64'(Read_data_Valid), 64'd0);
    cpu_mem_rvalid = 1'b1; cpu_mem_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    cpu_mem_rvalid = 1'b0; cpu_mem_rdata = '0;
    checkOutput("rd0_valid", 64'(Read_data_Valid), 64'd1);
    checkOutput("rd0_data", 64'(Read_data), 64'hDEAD_BEEF);
    checkOutput("rd0_rready_low", 64'(cpu_mem_rready), 64'd0);
    Read_data_Ready = 1'b1;
    applyStimulus();
    Read_data_Ready = 1'b0;
    checkOutput("rd0_done", 64'({Mem_Req_Ready, Read_data_Valid}), 64'b10);

    // Read with slow arready and slow CPU consumer
    $display("[TB] backpressured read");
    MemRead = 1'b1; Address = 32'h0000_2008;
    applyStimulus();
    MemRead = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_arvalid_%0d", i), 64'(cpu_mem_arvalid), 64'd1);
      checkOutput($sformatf("bp_araddr_%0d", i), 64'(cpu_mem_araddr), 64'h00_0000_2008);
      checkOutput($sformatf("bp_busy_ar_%0d", i), 64'(Mem_Req_Ready), 64'd0);
      applyStimulus();
    end
    cpu_mem_arready = 1'b1;
    applyStimulus();
    cpu_mem_arready = 1'b0;
    checkOutput("bp_rready", 64'(cpu_mem_rready), 64'd1);
    cpu_mem_rvalid = 1'b1; cpu_mem_rdata = 32'hCAFE_F00D;
    applyStimulus();
    cpu_mem_rvalid = 1'b0; cpu_mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_hold_valid_%0d", i), 64'(Read_data_Valid), 64'd1);
      checkOutput($sformatf("bp_hold_data_%0d", i), 64'(Read_data), 64'hCAFE_F00D);
      checkOutput($sformatf("bp_busy_rsp_%0d", i), 64'(Mem_Req_Ready), 64'd0);
      applyStimulus();
    end
    Read_data_Ready = 1'b1;
    checkOutput("bp_valid_at_ready", 64'(Read_data_Valid), 64'd1);
    applyStimulus();
    Read_data_Ready = 1'b0;
    checkOutput("bp_done", 64'({Mem_Req_Ready, Read_data_Valid}), 64'b10);

    // Write with W accepted three cycles before AW
    $display("[TB] split write");
    MemWrite = 1'b1; Address = 32'h0000_3003; Write_data = 32'h1234_5678; Write_strb = 4'b0011;
    applyStimulus();
    MemWrite = 1'b0; Write_data = '0; Write_strb = '0;
    checkOutput("sw_valids", 64'({cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_arvalid}), 64'b110);
    checkOutput("sw_awaddr", 64'(cpu_mem_awaddr), 64'h00_0000_3000);
    checkOutput("sw_wdata", 64'(cpu_mem_wdata), 64'h1234_5678);
    checkOutput("sw_wstrb", 64'(cpu_mem_wstrb), 64'b0011);
    checkOutput("sw_wlast", 64'(cpu_mem_wlast), 64'd1);
    checkOutput("sw_awlen_size", 64'({cpu_mem_awlen, cpu_mem_awsize, cpu_mem_awburst}), 64'({8'd0, 3'd2, 2'd1}));
    cpu_mem_wready = 1'b1;
    applyStimulus();
    cpu_mem_wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("sw_aw_only_%0d", i), 64'({cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_bready}), 64'b100);
      applyStimulus();
    end
    cpu_mem_awready = 1'b1;
    checkOutput("sw_aw_before_hs", 64'({cpu_mem_awvalid, cpu_mem_bready}), 64'b10);
    applyStimulus();
    cpu_mem_awready = 1'b0;
    checkOutput("sw_bready", 64'({cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_bready}), 64'b001);
    applyStimulus();
    checkOutput("sw_wait_b", 64'({cpu_mem_bready, Mem_Req_Ready}), 64'b10);
    cpu_mem_bvalid = 1'b1;
    applyStimulus();
    cpu_mem_bvalid = 1'b0;
    checkOutput("sw_done", 64'({cpu_mem_bready, Mem_Req_Ready}), 64'b01);
    checkOutput("sw_no_rsp", 64'(Read_data_Valid), 64'd0);

    // Simultaneous write and read: write wins
    $display("[TB] simultaneous request");
    MemWrite = 1'b1; MemRead = 1'b1; Address = 32'h0000_4000; Write_data = 32'h0BAD_F00D; Write_strb = 4'hF;
    applyStimulus();
    MemWrite = 1'b0; MemRead = 1'b0;
    checkOutput("sim_channels", 64'({cpu_mem_arvalid, cpu_mem_awvalid, cpu_mem_wvalid}), 64'b011);
    checkOutput("sim_wdata", 64'(cpu_mem_wdata), 64'h0BAD_F00D);
    cpu_mem_awready = 1'b1; cpu_mem_wready = 1'b1;
    applyStimulus();
    cpu_mem_awready = 1'b0; cpu_mem_wready = 1'b0;
    checkOutput("sim_bready", 64'({cpu_mem_arvalid, cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_bready}), 64'b0001);
    cpu_mem_bvalid = 1'b1;
    applyStimulus();
    cpu_mem_bvalid = 1'b0;
    checkOutput("sim_done", 64'({Mem_Req_Ready, cpu_mem_arvalid}), 64'b10);

    // Asynchronous reset in the middle of a read
    $display("[TB] reset mid-read");
    MemRead = 1'b1; Address = 32'h0000_5000;
    applyStimulus();
    MemRead = 1'b0;
    cpu_mem_arready = 1'b1;
    applyStimulus();
    cpu_mem_arready = 1'b0;
    checkOutput("rr_in_rd_r", 64'({cpu_mem_rready, Mem_Req_Ready}), 64'b10);
    #2 cpu_reset_n = 1'b0;
    #1;
    checkOutput("rr_async_outputs", 64'({Mem_Req_Ready, cpu_mem_rready, Read_data_Valid, cpu_mem_arvalid}), 64'b1000);
    checkOutput("rr_async_rdata", 64'(Read_data), 64'd0);
    checkOutput("rr_async_addr", 64'(cpu_mem_araddr), 64'd0);
    applyStimulus();
    cpu_reset_n = 1'b1;
    applyStimulus();
    checkOutput("rr_after_release", 64'({Mem_Req_Ready, cpu_mem_rready, cpu_mem_arvalid}), 64'b100);

    // Write then read with both requests held high
    $display("[TB] back-to-back");
    MemWrite = 1'b1; Address = 32'h0000_6000; Write_data = 32'hAABB_CCDD; Write_strb = 4'hF;
    applyStimulus();
    MemWrite = 1'b0; MemRead = 1'b1; Address = 32'h0000_6100;
    checkOutput("b2b_aw", 64'({cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_arvalid}), 64'b110);
    cpu_mem_awready = 1'b1; cpu_mem_wready = 1'b1;
    applyStimulus();
    cpu_mem_awready = 1'b0; cpu_mem_wready = 1'b0;
    checkOutput("b2b_wr_b", 64'({cpu_mem_bready, Mem_Req_Ready, cpu_mem_arvalid}), 64'b100);
    cpu_mem_bvalid = 1'b1;
    applyStimulus();
    cpu_mem_bvalid = 1'b0;
    checkOutput("b2b_idle", 64'({Mem_Req_Ready, cpu_mem_arvalid}), 64'b10);
    applyStimulus();
    MemRead = 1'b0;
    checkOutput("b2b_read_accept", 64'({cpu_mem_arvalid, Mem_Req_Ready}), 64'b10);
    checkOutput("b2b_araddr", 64'(cpu_mem_araddr), 64'h00_0000_6100);
    cpu_mem_arready = 1'b1;
    applyStimulus();
    cpu_mem_arready = 1'b0;
    cpu_mem_rvalid = 1'b1; cpu_mem_rdata = 32'h5A5A_A5A5;
    applyStimulus();
    cpu_mem_rvalid = 1'b0;
    checkOutput("b2b_rdata", 64'({Read_data_Valid, Read_data}), 64'h1_5A5A_A5A5);
    Read_data_Ready = 1'b1;
    applyStimulus();
    Read_data_Ready = 1'b0;
    checkOutput("b2b_done", 64'({Mem_Req_Ready, Read_data_Valid}), 64'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_axi_bridge.md
# data_mem_axi_bridge

Converts the custom CPU's data-memory request/response handshake (Address/MemWrite/MemRead/Read_data) into single-beat AXI4 read and write transactions on the `cpu_mem_*` channels. It sits between `custom_cpu` and the 2x1 AXI arbiter, on the path taken by uncached data accesses. At most one transaction is outstanding. Reads return data to the CPU through a held valid/ready response.

## Interface
- AXI_ADDR_WIDTH, 40: width of `cpu_mem_araddr` and `cpu_mem_awaddr`; the upper bits above 32 are driven 0.
- cpu_clk  in  1  single clock.
- cpu_reset_n  in  1  reset; asynchronous and active-low.
- Address  in  32  byte address of the CPU request.
- MemWrite / MemRead  in  1 each  CPU write / read request valid.
- Write_data  in  32  store data.
- Write_strb  in  4  byte enables.
- Mem_Req_Ready  out  1  request accepted when high together with MemWrite or MemRead.
- Read_data  out  32  load data.
- Read_data_Valid  out  1  load data valid.
- Read_data_Ready  in  1  CPU accepts load data.
- cpu_mem_araddr  out  AXI_ADDR_WIDTH  read address.
- cpu_mem_arvalid / cpu_mem_arready  out / in  1  read-address handshake.
- cpu_mem_arsize / cpu_mem_arburst / cpu_mem_arlen  out  3/2/8  constants 3'b010 / 2'b01 / 8'd0.
- cpu_mem_rdata  in  32  read data.
- cpu_mem_rvalid / cpu_mem_rready / cpu_mem_rlast  in / out / in  1  read-data handshake.
- cpu_mem_awaddr, awvalid, awready, awsize, awburst, awlen  same shape and constants as the AR channel.
- cpu_mem_wdata  out  32  write data.
- cpu_mem_wstrb  out  4  write strobes.
- cpu_mem_wvalid / cpu_mem_wready / cpu_mem_wlast  out / in / out  1  write-data channel; wlast is tied to 1.
- cpu_mem_bvalid / cpu_mem_bready  in / out  1  write response.

## Operation
- States are IDLE, RD_AR, RD_R, RD_RSP, WR_REQ and WR_B.
- **IDLE**
  - Mem_Req_Ready=1.
  - MemWrite=1 captures Address, Write_data and Write_strb, then moves to WR_REQ.
  - If MemWrite is low, MemRead=1 captures Address and moves to RD_AR.
  - When MemWrite and MemRead are both asserted, the write wins and the read is not accepted.
- **RD_AR**
  - arvalid=1 with araddr={zeros, addr[31:2], 2'b00}.
  - arvalid stays high until arready is sampled high, then the state moves to RD_R.
- **RD_R**
  - rready=1.
  - On rvalid, rdata is latched into the Read_data register and the state moves to RD_RSP.
  - rlast is not checked, because arlen is 0.
- **RD_RSP**
  - Read_data_Valid=1, and Read_data holds steady.
  - On Read_data_Ready the state returns to IDLE.
- **WR_REQ**
  - awvalid and wvalid rise together.
  - Each one drops independently on its own handshake, tracked by flags aw_done and w_done; a handshake may land in the same cycle on both channels or on either one first.
  - awaddr is aligned like araddr.
  - wdata and wstrb come from the captured registers.
  - Once both handshakes are done, the state moves to WR_B.
- **WR_B**
  - bready=1.
  - On bvalid the state returns to IDLE.
  - No response is sent to the CPU for writes.
- Mem_Req_Ready is high only in IDLE.
- All AXI outputs come from registers or from the state; there is no combinational path from any CPU input to any AXI output.
- Reset, whether idle or mid-transaction, asynchronously forces IDLE. It clears all valids, readies, done flags and Read_data (value 0). A half-finished AXI transaction is abandoned, and the slave is reset by the same signal.

## Timing
- Reset values: Mem_Req_Ready=1; Read_data_Valid=0; Read_data=0; arvalid, awvalid, wvalid, rready and bready all 0; addresses, wdata and wstrb 0.
- Read with a zero-wait slave:
  - request accepted at edge 0;
  - arvalid high during cycle 1, arready also in cycle 1;
  - rready in cycle 2, rvalid in cycle 2;
  - Read_data_Valid in cycle 3.
  - Minimum latency from acceptance to data valid is 3 cycles.
  - Mem_Req_Ready returns in the cycle after the Read_data_Ready handshake.
- Write with a zero-wait slave:
  - aw and w in cycle 1;
  - bready and bvalid in cycle 2;
  - Mem_Req_Ready high again in cycle 3.
- AXI valids never drop before their ready is seen.
- Read_data_Valid stays held indefinitely while Read_data_Ready is low.

## Test plan
- Read, zero wait: MemRead with Address=0x0000_1006 and a slave that returns 0xDEADBEEF.
  - araddr must be 0x00_0000_1004, arlen=0, arsize=2.
  - Read_data_Valid must rise 3 cycles after acceptance with Read_data=0xDEADBEEF.
- Backpressure: arready delayed 5 cycles and Read_data_Ready delayed 4 cycles.
  - arvalid and araddr must stay stable.
  - Read_data_Valid must hold for 4 cycles.
  - Mem_Req_Ready stays 0 throughout.
- Split write: Write_data=0x1234_5678, Write_strb=4'b0011, with wready 3 cycles before awready.
  - wvalid must drop after its handshake while awvalid persists.
  - bready must assert only after both handshakes.
  - The transaction must finish on bvalid.
- Simultaneous request: MemWrite=MemRead=1.
  - Only the AW/W channels may activate; arvalid must stay 0.
- Reset mid-read: assert cpu_reset_n=0 during RD_R.
  - Outputs must go to reset values immediately, without waiting for a clock edge.
  - After release, Mem_Req_Ready=1.
- Back-to-back: a write followed by a read, with requests held high.
  - The second request must be accepted on the first IDLE cycle after the B handshake.
